// File: rtl/output_port_pkg.sv
// Shared types and constants for the output_port block (value-to-BCD display driver).
// Optional feature macro: OUTPUT_ACK_EN (hold halt until the ack button is pressed).
package output_port_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CONVERT  = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_e;

   // Default geometry: 10 internal BCD digits cover the full 32-bit unsigned range
   localparam int OP_DATA_WIDTH = 32;
   localparam int OP_NUM_DIGITS = 4;
   localparam int OP_BCD_DIGITS = 10;

   // Double-dabble nibble correction: any nibble >= 5 gets +3 before the shift
   localparam logic [3:0] NIBBLE_ADJ_THRESH = 4'd5;
   localparam logic [3:0] NIBBLE_ADJ        = 4'd3;

   // Width of a down-counter that must hold the value w
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int OP_CNT_W = cnt_width(OP_DATA_WIDTH);

endpackage

// File: rtl/output_port_bcd_shift_step.sv
// One double-dabble iteration: add-3 correction on every BCD nibble, then shift the
// BCD register left by one, pulling in the next binary MSB at bit 0.
module bcd_shift_step
   import output_port_pkg::*;
#(
   parameter int BCD_DIGITS = OP_BCD_DIGITS
) (
   input  logic [4*BCD_DIGITS-1:0] bcd_in,
   input  logic                    msb_in,
   output logic [4*BCD_DIGITS-1:0] bcd_out
);

   logic [4*BCD_DIGITS-1:0] adj_s;

   // Correct each nibble, then shift the corrected value left with the binary MSB appended
   always_comb begin
      adj_s = bcd_in;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_in[4*i +: 4] >= NIBBLE_ADJ_THRESH) begin
            adj_s[4*i +: 4] = bcd_in[4*i +: 4] + NIBBLE_ADJ;
         end else begin
            adj_s[4*i +: 4] = bcd_in[4*i +: 4];
         end
      end
      bcd_out = (adj_s << 1) | {{(4*BCD_DIGITS-1){1'b0}}, msb_in};
   end

endmodule

// File: rtl/output_port.sv
// output_port: accepts one write per OUT instruction, converts the value to BCD by
// sequential double-dabble (one bit per clock) while holding the CPU halted, then
// updates the four display digits and the overflow flag together.
// Optional feature macro: OUTPUT_ACK_EN -- after conversion, stay halted until a
// rising edge of the debounced button.
module output_port
   import output_port_pkg::*;
#(
   parameter int DATA_WIDTH = OP_DATA_WIDTH,
   parameter int NUM_DIGITS = OP_NUM_DIGITS,
   parameter int BCD_DIGITS = OP_BCD_DIGITS
) (
   input  logic                  clock,
   input  logic                  reseta,
   input  logic                  write_strobe,
   input  logic [DATA_WIDTH-1:0] value,
   input  logic                  button,
   output logic                  halt_from_output,
   output logic [3:0]            digit0,
   output logic [3:0]            digit1,
   output logic [3:0]            digit2,
   output logic [3:0]            digit3,
   output logic                  overflow
);

   localparam int               CNT_W    = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
   logic                    ovf_q, ovf_d;
   logic                    halt_q, halt_d;
   logic [4*BCD_DIGITS-1:0] bcd_next_s;
   logic                    btn_rise_s;

   bcd_shift_step #(
      .BCD_DIGITS (BCD_DIGITS)
   ) u_step (
      .bcd_in  (bcd_q),
      .msb_in  (shift_q[DATA_WIDTH-1]),
      .bcd_out (bcd_next_s)
   );

`ifdef OUTPUT_ACK_EN
   logic button_q, button_d;

   assign button_d   = button;
   assign btn_rise_s = button & ~button_q;

   // Registered copy of the button level for rising-edge detection
   always_ff @(posedge clock) begin
      if (!reseta) begin
         button_q <= 1'b0;
      end else begin
         button_q <= button_d;
      end
   end
`else
   logic unused_button_s;

   assign unused_button_s = button;
   assign btn_rise_s      = 1'b0;
`endif

   // Next-state logic: accept a write in IDLE, run one double-dabble step per clock,
   // and publish digits/overflow in one shot on the final step
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      halt_d  = halt_q;
      case (state_q)
         ST_IDLE: begin
            if (write_strobe) begin
               shift_d = value;
               bcd_d   = {(4*BCD_DIGITS){1'b0}};
               cnt_d   = CNT_LOAD;
               state_d = ST_CONVERT;
               halt_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
               halt_d  = 1'b0;
            end
         end
         ST_CONVERT: begin
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            bcd_d   = bcd_next_s;
            cnt_d   = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
               // Low nibbles go to the display; any nonzero higher nibble means overflow
               disp_d = bcd_next_s[4*NUM_DIGITS-1:0];
               ovf_d  = |bcd_next_s[4*BCD_DIGITS-1:4*NUM_DIGITS];
`ifdef OUTPUT_ACK_EN
               state_d = ST_WAIT_ACK;
               halt_d  = 1'b1;
`else
               state_d = ST_IDLE;
               halt_d  = 1'b0;
`endif
            end else begin
               state_d = ST_CONVERT;
               halt_d  = 1'b1;
            end
         end
         ST_WAIT_ACK: begin
            // Only a fresh press releases; a held level cannot release twice
            if (btn_rise_s) begin
               state_d = ST_IDLE;
               halt_d  = 1'b0;
            end else begin
               state_d = ST_WAIT_ACK;
               halt_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            halt_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion and blanks the display
   always_ff @(posedge clock) begin
      if (!reseta) begin
         state_q <= ST_IDLE;
         shift_q <= {DATA_WIDTH{1'b0}};
         bcd_q   <= {(4*BCD_DIGITS){1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         disp_q  <= {(4*NUM_DIGITS){1'b0}};
         ovf_q   <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         halt_q  <= halt_d;
      end
   end

   assign halt_from_output = halt_q;
   assign overflow         = ovf_q;
   assign digit0           = disp_q[3:0];
   assign digit1           = disp_q[7:4];
   assign digit2           = disp_q[11:8];
   assign digit3           = disp_q[15:12];

endmodule

// File: tb/tb_output_port.sv
// Scoreboard bench for output_port: each accepted write pushes its expected display
// (value mod 10000 as decimal digits, plus overflow) and a negedge monitor pops and
// compares when the conversion completes.
module tb_output_port;

   logic        clock = 1'b0;
   logic        reseta = 1'b0;
   logic        write_strobe = 1'b0;
   logic [31:0] value = 32'd0;
   logic        button = 1'b0;
   logic        halt;
   logic [3:0]  d0, d1, d2, d3;
   logic        ovf;

   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          halt_cnt = 0;
   logic [16:0] exp_q[$];
   logic [16:0] mon_exp;

   output_port dut (
      .clock            (clock),
      .reseta           (reseta),
      .write_strobe     (write_strobe),
      .value            (value),
      .button           (button),
      .halt_from_output (halt),
      .digit0           (d0),
      .digit1           (d1),
      .digit2           (d2),
      .digit3           (d3),
      .overflow         (ovf)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: decimal arithmetic on the unsigned value, {overflow, d3,d2,d1,d0}
   function automatic logic [16:0] model(input logic [31:0] v);
      longint unsigned vv, r, p;
      logic [16:0]     e;
      vv = {32'd0, v};
      r  = vv % 64'd10000;
      p  = 64'd1;
      e  = 17'd0;
      for (int i = 0; i < 4; i++) begin
         e[4*i +: 4] = 4'((r / p) % 64'd10);
         p = p * 64'd10;
      end
      e[16] = (vv >= 64'd10000);
      return e;
   endfunction

   // Monitor: the sample after 32 consecutive halt-high samples shows the new result
   always @(negedge clock) begin
      if (!reseta) begin
         exp_q.delete();
         halt_cnt = 0;
      end else begin
         if (halt_cnt == 32) begin
            if (exp_q.size() == 0) begin
               check("sb_nonempty", 32'd0, 32'd1);
            end else begin
               mon_exp = exp_q.pop_front();
               check("digits", {16'd0, d3, d2, d1, d0}, {16'd0, mon_exp[15:0]});
               check("overflow", {31'd0, ovf}, {31'd0, mon_exp[16]});
            end
`ifdef OUTPUT_ACK_EN
            check("halt_wait_ack", {31'd0, halt}, 32'd1);
`else
            check("halt_release", {31'd0, halt}, 32'd0);
`endif
            done_cnt++;
         end
`ifndef OUTPUT_ACK_EN
         if (!halt && halt_cnt != 0) check("halt_len", halt_cnt, 32'd32);
`endif
         halt_cnt = halt ? halt_cnt + 1 : 0;
      end
   end

   task automatic issue(input logic [31:0] v, input bit accept);
      value        = v;
      write_strobe = 1'b1;
      if (accept) exp_q.push_back(model(v));
      @(posedge clock);
      #1;
      write_strobe = 1'b0;
   endtask

   task automatic ack();
      int highs;
      highs = 0;
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      check("halt_held", {31'd0, halt}, 32'd1);
      button = 1'b1;
      @(posedge clock);
      #1;
      check("halt_ack", {31'd0, halt}, 32'd0);
      repeat (99) begin
         @(posedge clock);
         #1;
         if (halt) highs++;
      end
      check("halt_stays_low", highs, 32'd0);
      button = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic wait_done();
      int start;
      bit ok;
      start = done_cnt;
      ok    = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clock);
         #1;
         if (done_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
      check("conv_done", {31'd0, ok}, 32'd1);
`ifdef OUTPUT_ACK_EN
      if (ok) ack();
`endif
   endtask

   task automatic check_blank(input string name);
      check({name, "_halt"}, {31'd0, halt}, 32'd0);
      check({name, "_digits"}, {16'd0, d3, d2, d1, d0}, 32'd0);
      check({name, "_ovf"}, {31'd0, ovf}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      reseta = 1'b0;
      @(posedge clock);
      #1;
      reseta = 1'b1;
      check_blank("reset");
      repeat (5) begin
         @(posedge clock);
         #1;
      end
      check_blank("idle");

      issue(32'd1234, 1'b1);        wait_done();
      issue(32'd12345, 1'b1);       wait_done();
      issue(32'hFFFF_FFFF, 1'b1);   wait_done();
      issue(32'd9999, 1'b1);        wait_done();
      issue(32'd10000, 1'b1);       wait_done();
      issue(32'd0, 1'b1);           wait_done();

      // Second strobe one cycle later lands in CONVERT and must be dropped
      issue(32'd4321, 1'b1);
      issue(32'd8765, 1'b0);
      wait_done();

      // Reset at conversion cycle 10 aborts and blanks the display
      issue(32'd5678, 1'b1);
      repeat (9) begin
         @(posedge clock);
         #1;
      end
      reseta = 1'b0;
      @(posedge clock);
      #1;
      reseta = 1'b1;
      check_blank("abort");
      issue(32'd42, 1'b1);          wait_done();

      // Strobe coincident with reset: reset wins
      value        = 32'd999;
      write_strobe = 1'b1;
      reseta       = 1'b0;
      @(posedge clock);
      #1;
      write_strobe = 1'b0;
      reseta       = 1'b1;
      check_blank("rst_strobe");
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      check("rst_strobe_idle", {31'd0, halt}, 32'd0);

      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) v = $urandom_range(0, 20000);
         else            v = $urandom;
         issue(v, 1'b1);
         wait_done();
      end

      check("sb_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
